duty_meas_sched: RTL and testbench
==================================

Name: duty_meas_sched

Overview:
- Time-multiplexes one shared duty-cycle/period measurement engine across N_CH input signals.
- Per measurement: selects the channel mux, waits a settle interval, pulses a start, then waits for done or a timeout.
- Delivers a tagged result over a valid/ready interface to the display/UART side.
- Sits between the input signal mux + measurement core and the result consumer.

Parameters:
- N_CH, 4, number of measured channels (2..16).
- CH_W, 2, channel index width; must equal clog2(N_CH).
- RES_W, 16, measurement result width (duty in 0.1 % units).
- SETTLE_CYC, 16, cycles between mux switch and start; must be >= 1.
- TIMEOUT_CYC, 50000000, maximum cycles to wait for done (1 s at 50 MHz); must be >= 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  run scheduling while high
- ch_mask  in  N_CH  per-channel enable; bit i = channel i participates
- ch_sel  out  CH_W  select for the input mux in front of the measurement core
- meas_start  out  1  one-cycle start pulse to the core
- meas_done  in  1  one-cycle completion pulse from the core
- meas_result  in  RES_W  core result; valid in the cycle meas_done is high
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_ch  out  CH_W  channel the result belongs to
- res_data  out  RES_W  result value
- res_timeout  out  1  result is a timeout (res_data = 0)
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All outputs go to 0: ch_sel, meas_start, res_valid, res_ch, res_data, res_timeout, busy.
  - Round-robin pointer goes to N_CH-1, so the first grant is channel 0.
  - Settle and timeout counters clear.
- FSM states: IDLE, SELECT, SETTLE, START, WAIT, OUTPUT.
- IDLE: if enable=1 and ch_mask!=0, go to SELECT; otherwise stay.
- SELECT (1 cycle):
  - Grant the first set bit of ch_mask searching ptr+1, ptr+2, … with wrap modulo N_CH.
  - Load ch_sel and the pointer with the grant.
  - ch_mask is sampled only here; later mask changes do not affect the measurement in flight.
  - If ch_mask has become 0 at this point, return to IDLE.
- SETTLE: count exactly SETTLE_CYC cycles, then go to START. ch_sel is stable from SELECT through OUTPUT.
- START (1 cycle): meas_start=1, timeout counter cleared, then go to WAIT. meas_start is never high in any other state.
- WAIT:
  - On meas_done=1: latch meas_result into res_data, set res_timeout=0, res_ch=ch_sel, go to OUTPUT.
  - Timeout: if the counter reaches TIMEOUT_CYC-1 with no done, set res_data=0, res_timeout=1, res_ch=ch_sel, go to OUTPUT.
  - If done and timeout fall in the same cycle, done wins.
  - meas_done in any state other than WAIT is ignored.
- OUTPUT:
  - res_valid=1; res_ch, res_data and res_timeout are held stable until the handshake.
  - Handshake completes on res_valid & res_ready.
  - On handshake: res_valid goes to 0. If enable=1 and ch_mask!=0, go to SELECT; otherwise go to IDLE.
  - res_ready with res_valid=0 has no effect.
- enable deassert mid-operation: the current measurement completes and is delivered, then the FSM goes to IDLE. There is no abort.
- Latency: with enable sampled high in IDLE on clock edge E0:
  - SELECT occupies E0+1.
  - meas_start is high in the cycle after edge E0+2+SETTLE_CYC.
  - A done pulse gives res_valid on the next edge.
- Counter widths: settle counter is clog2(SETTLE_CYC+1) bits; timeout counter is 32 bits. Neither wraps while in use.
- Single-bit ch_mask: the same channel is measured repeatedly.

Test Plan:
- Reset mid-WAIT (assert rst_n=0) -> all outputs 0 asynchronously. After release with enable=1 and mask=4'b1111, the first res_ch=0.
- mask=4'b1111, core model returns 100*(ch+1), res_ready=1 -> results in order ch0..ch3,ch0 with res_data 100, 200, 300, 400, 100; res_timeout=0 throughout.
- mask=4'b1010 -> res_ch sequence 1,3,1,3. Change mask to 4'b0100 during WAIT of ch3 -> next grant is ch2.
- TIMEOUT_CYC=100, core never pulses done -> res_valid exactly 100 cycles after meas_start, with res_timeout=1 and res_data=0. Repeat with done arriving on cycle 99, the same cycle the counter reaches TIMEOUT_CYC-1 -> res_timeout=0 and res_data=meas_result.
- res_ready=0 for 50 cycles in OUTPUT -> res_valid, res_ch and res_data stay stable, with no meas_start until the handshake; ready=1 -> SELECT on the next edge.
- enable dropped during SETTLE -> meas_start still fires and the result is delivered; after the handshake busy=0 and there is no further meas_start.

Source files
------------

// File: rtl/duty_meas_sched.sv
// Round-robin scheduler that time-shares one duty/period measurement core across
// N_CH muxed inputs and hands each tagged result to a valid/ready consumer.
module duty_meas_sched #(
  parameter int N_CH        = 4,
  parameter int CH_W        = 2,
  parameter int RES_W       = 16,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [N_CH-1:0]  ch_mask,
  output logic [CH_W-1:0]  ch_sel,
  output logic             meas_start,
  input  logic             meas_done,
  input  logic [RES_W-1:0] meas_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CH_W-1:0]  res_ch,
  output logic [RES_W-1:0] res_data,
  output logic             res_timeout,
  output logic             busy
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    SETTLE,
    START,
    WAIT,
    OUTPUT
  } state_t;

  state_t             state_q, state_d;
  logic [CH_W-1:0]    ptr_q, ptr_d;
  logic [CH_W-1:0]    ch_sel_q, ch_sel_d;
  logic [SET_W-1:0]   set_q, set_d;
  logic [31:0]        tmo_q, tmo_d;
  logic [CH_W-1:0]    res_ch_q, res_ch_d;
  logic [RES_W-1:0]   res_data_q, res_data_d;
  logic               res_tmo_q, res_tmo_d;

  // First set mask bit strictly after ptr, wrapping modulo N_CH.
  function automatic logic [CH_W-1:0] rr_pick(input logic [N_CH-1:0] mask,
                                              input logic [CH_W-1:0] ptr);
    logic [CH_W-1:0] idx;
    logic [CH_W-1:0] pick;
    logic            found;
    idx   = ptr;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      idx = (idx == CH_W'(N_CH - 1)) ? '0 : idx + 1'b1;
      if (!found && mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    ch_sel_d   = ch_sel_q;
    set_d      = '0;
    tmo_d      = '0;
    res_ch_d   = res_ch_q;
    res_data_d = res_data_q;
    res_tmo_d  = res_tmo_q;

    case (state_q)
      IDLE: begin
        if (enable && (|ch_mask)) state_d = SELECT;
      end

      SELECT: begin
        if (|ch_mask) begin
          ch_sel_d = rr_pick(ch_mask, ptr_q);
          ptr_d    = ch_sel_d;
          state_d  = SETTLE;
        end else begin
          state_d = IDLE;
        end
      end

      SETTLE: begin
        if (set_q == SET_W'(SETTLE_CYC - 1)) state_d = START;
        else                                  set_d   = set_q + 1'b1;
      end

      // Timeout counter reads 0 during START, so WAIT cycle k sees count k.
      START: begin
        tmo_d   = tmo_q + 32'd1;
        state_d = WAIT;
      end

      WAIT: begin
        if (meas_done) begin
          res_data_d = meas_result;
          res_tmo_d  = 1'b0;
          res_ch_d   = ch_sel_q;
          state_d    = OUTPUT;
        end else if (tmo_q == 32'(TIMEOUT_CYC - 1)) begin
          res_data_d = '0;
          res_tmo_d  = 1'b1;
          res_ch_d   = ch_sel_q;
          state_d    = OUTPUT;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end

      OUTPUT: begin
        if (res_ready) state_d = (enable && (|ch_mask)) ? SELECT : IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= CH_W'(N_CH - 1);
      ch_sel_q   <= '0;
      set_q      <= '0;
      tmo_q      <= '0;
      res_ch_q   <= '0;
      res_data_q <= '0;
      res_tmo_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ch_sel_q   <= ch_sel_d;
      set_q      <= set_d;
      tmo_q      <= tmo_d;
      res_ch_q   <= res_ch_d;
      res_data_q <= res_data_d;
      res_tmo_q  <= res_tmo_d;
    end
  end

  // Strobes decode straight from the state register so reset clears them at once.
  assign ch_sel      = ch_sel_q;
  assign meas_start  = (state_q == START);
  assign res_valid   = (state_q == OUTPUT);
  assign busy        = (state_q != IDLE);
  assign res_ch      = res_ch_q;
  assign res_data    = res_data_q;
  assign res_timeout = res_tmo_q;

endmodule

// File: tb/tb_duty_meas_sched.sv
// Directed, table-driven bench for duty_meas_sched with hand-computed results,
// plus hand-written sequences for timeout, backpressure, enable drop and reset.
module tb_duty_meas_sched;

  localparam int N_CH   = 4;
  localparam int CH_W   = 2;
  localparam int RES_W  = 16;
  localparam int SETTLE = 4;
  localparam int TMO    = 100;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic [N_CH-1:0]  ch_mask;
  logic [CH_W-1:0]  ch_sel;
  logic             meas_start;
  logic             meas_done;
  logic [RES_W-1:0] meas_result;
  logic             res_valid;
  logic             res_ready;
  logic [CH_W-1:0]  res_ch;
  logic [RES_W-1:0] res_data;
  logic             res_timeout;
  logic             busy;

  duty_meas_sched #(
    .N_CH(N_CH), .CH_W(CH_W), .RES_W(RES_W), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ch_mask(ch_mask), .ch_sel(ch_sel),
    .meas_start(meas_start), .meas_done(meas_done), .meas_result(meas_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch), .res_data(res_data),
    .res_timeout(res_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [N_CH-1:0] mask_next;
    int              dly;
    int              exp_ch;
    int              exp_data;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_start(input string name, output int at);
    int i;
    at = -1;
    i  = 0;
    while (at < 0 && i < 300) begin
      @(negedge clk);
      if (meas_start === 1'b1) at = cyc;
      i++;
    end
    if (at < 0) begin
      nvec++;
      nerr++;
      $display("FAIL %s: no meas_start within 300 cycles", name);
    end
  endtask

  // Core model: answers dly cycles after the start with 100*(ch+1).
  task automatic do_txn(input vec_t v, input int k, output int t);
    wait_start($sformatf("v%0d_start", k), t);
    if (t < 0) return;
    chk($sformatf("v%0d_ch_sel", k), 32'(ch_sel), v.exp_ch);
    ch_mask = v.mask_next;
    repeat (v.dly) @(negedge clk);
    chk($sformatf("v%0d_pre_valid", k), 32'(res_valid), 0);
    meas_done   = 1'b1;
    meas_result = 16'(100 * (int'(ch_sel) + 1));
    @(negedge clk);
    meas_done   = 1'b0;
    meas_result = 16'hDEAD;
    chk($sformatf("v%0d_valid", k), 32'(res_valid), 1);
    chk($sformatf("v%0d_res_ch", k), 32'(res_ch), v.exp_ch);
    chk($sformatf("v%0d_res_data", k), 32'(res_data), v.exp_data);
    chk($sformatf("v%0d_res_tmo", k), 32'(res_timeout), 0);
  endtask

  initial begin
    int  e0, t, t0, tv, s;
    bit  ok;
    vec_t vx;

    vt[0]  = '{4'b1111, 1, 0, 100};
    vt[1]  = '{4'b1111, 2, 1, 200};
    vt[2]  = '{4'b1111, 3, 2, 300};
    vt[3]  = '{4'b1111, 1, 3, 400};
    vt[4]  = '{4'b1010, 2, 0, 100};
    vt[5]  = '{4'b1010, 1, 1, 200};
    vt[6]  = '{4'b1010, 1, 3, 400};
    vt[7]  = '{4'b1010, 2, 1, 200};
    vt[8]  = '{4'b0100, 1, 3, 400};
    vt[9]  = '{4'b0100, 1, 2, 300};
    vt[10] = '{4'b0100, 1, 2, 300};

    rst_n       = 1'b0;
    enable      = 1'b0;
    ch_mask     = '0;
    meas_done   = 1'b0;
    meas_result = '0;
    res_ready   = 1'b1;

    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({ch_sel, meas_start, res_valid, res_ch, res_data, res_timeout, busy}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_enable", 32'(busy), 0);

    // Round robin over full mask, then 1010, then a mid-WAIT switch to 0100.
    ch_mask = 4'b1111;
    enable  = 1'b1;
    e0      = cyc;
    @(negedge clk);
    chk("select_busy", 32'(busy), 1);
    for (int k = 0; k < 11; k++) begin
      do_txn(vt[k], k, t);
      if (k == 0) chk("start_latency", t, e0 + 2 + SETTLE);
    end

    // Core silent: timeout result exactly TMO cycles after the start.
    wait_start("tmo_start", t0);
    tv = -1;
    for (int i = 0; i < 200 && tv < 0; i++) begin
      @(negedge clk);
      if (res_valid === 1'b1) tv = cyc;
    end
    chk("tmo_delay", tv - t0, TMO);
    chk("tmo_flag", 32'(res_timeout), 1);
    chk("tmo_data", 32'(res_data), 0);
    chk("tmo_ch", 32'(res_ch), 2);

    // Done on the last counted cycle beats the timeout.
    wait_start("race_start", t0);
    repeat (TMO - 1) @(negedge clk);
    chk("race_pre_valid", 32'(res_valid), 0);
    meas_done   = 1'b1;
    meas_result = 16'd1234;
    @(negedge clk);
    meas_done   = 1'b0;
    meas_result = '0;
    chk("race_valid", 32'(res_valid), 1);
    chk("race_tmo", 32'(res_timeout), 0);
    chk("race_data", 32'(res_data), 1234);
    @(negedge clk);
    res_ready = 1'b0;

    // Backpressure: result must hold, stray done ignored, no new start.
    wait_start("bp_start", t0);
    @(negedge clk);
    meas_done   = 1'b1;
    meas_result = 16'(300);
    @(negedge clk);
    meas_done = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (!(res_valid === 1'b1 && res_ch === 2'd2 && res_data === 16'd300 &&
            res_timeout === 1'b0 && meas_start === 1'b0 && busy === 1'b1)) ok = 1'b0;
      meas_done   = (i == 10);
      meas_result = 16'd999;
      @(negedge clk);
    end
    meas_done = 1'b0;
    chk("bp_hold_stable", 32'(ok), 1);
    res_ready = 1'b1;
    @(negedge clk);
    s = cyc;
    chk("bp_release_valid", 32'(res_valid), 0);
    chk("bp_release_select", 32'(busy), 1);

    // Enable dropped during SETTLE: measurement still completes, then idle.
    @(negedge clk);
    enable = 1'b0;
    vx = '{4'b0100, 1, 2, 300};
    do_txn(vx, 11, t);
    chk("drop_start_latency", t, s + 1 + SETTLE);
    @(negedge clk);
    chk("drop_idle", 32'(busy), 0);
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (meas_start !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    chk("drop_no_restart", 32'(ok), 1);

    // Asynchronous reset mid-WAIT, then restart from channel 0.
    ch_mask = 4'b1111;
    enable  = 1'b1;
    wait_start("rst_start", t0);
    chk("rst_pre_ch", 32'(ch_sel), 3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_outputs",
           32'({ch_sel, meas_start, res_valid, res_ch, res_data, res_timeout, busy}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    vx = '{4'b1111, 1, 0, 100};
    do_txn(vx, 12, t);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
